// File: rtl/parity_frame_tx.sv
// Serial parity-frame transmitter: word out LSB-first, then one parity bit; bit 0 one cycle after handshake.
// Backpressure: data_ready drops for the data bits and reopens in the parity cycle for gapless frames.
module parity_frame_tx #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              par_q, par_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;
  logic              busy_q, busy_d;
  logic              take;

  assign data_ready = (state_q != S_DATA);
  assign take       = data_valid && data_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE, S_PARITY: begin
        if (take) begin
          state_d = S_DATA;
          word_d  = data_in;
          par_d   = (^data_in) ^ ODD_PARITY;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_PARITY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so bit 0 lands in the cycle right after the handshake.
  always_comb begin
    bit_out_d     = 1'b0;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    busy_d        = (state_d != S_IDLE);
    case (state_d)
      S_DATA: begin
        bit_out_d     = word_d[idx_d];
        bit_valid_d   = 1'b1;
        frame_start_d = (idx_d == '0);
      end
      S_PARITY: begin
        bit_out_d   = par_d;
        bit_valid_d = 1'b1;
        frame_end_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      word_q        <= '0;
      par_q         <= 1'b0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      par_q         <= par_d;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      busy_q        <= busy_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign busy        = busy_q;

endmodule
